// File: rtl/uart_tx_serializer_if.sv
// Byte handshake between a UART transmit producer and the serializer.
// The producer drives the data/valid pair; the serializer answers with ready.
interface uart_tx_serializer_if #(
  parameter int DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: one-word holding buffer in front of a start/data/parity/stop
// shifter that advances once per rising edge of the baud generator level.
module uart_tx_serializer #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                baud_tick,
  uart_tx_serializer_if.slave bus,
  output logic                tx,
  output logic                tx_busy
);

  localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] LAST_DATA = CW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } state_t;

  state_t                state_q;
  logic                  tick_q;
  logic                  full_q;
  logic                  stop_q;
  logic [CW-1:0]         cnt_q;
  logic                  tx_q;
  logic                  busy_q;
  logic [DATA_BITS-1:0]  buf_q;
  logic [DATA_BITS-1:0]  shift_q;
  logic                  par_q;

  logic strobe;
  logic accept;
  logic stop_done;
  logic load;
  logic shift_en;

  // baud_tick is a level, so only its rising edge advances the line
  assign strobe    = baud_tick & ~tick_q;
  assign accept    = bus.tx_valid & ~full_q;
  assign stop_done = (STOP_BITS == 1) || stop_q;
  assign load      = strobe & full_q &
                     ((state_q == ST_IDLE) || ((state_q == ST_STOP) && stop_done));
  assign shift_en  = strobe & (state_q == ST_DATA) & (cnt_q != LAST_DATA);

  assign bus.tx_ready = ~full_q;
  assign tx           = tx_q;
  assign tx_busy      = busy_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      tick_q  <= 1'b0;
      full_q  <= 1'b0;
      stop_q  <= 1'b0;
      cnt_q   <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      tick_q <= baud_tick;
      // accept and load are mutually exclusive: accept needs full_q low, load needs it high
      if (accept) begin
        full_q <= 1'b1;
      end
      if (load) begin
        full_q  <= 1'b0;
        tx_q    <= 1'b0;
        busy_q  <= 1'b1;
        state_q <= ST_START;
      end else if (strobe) begin
        case (state_q)
          ST_START: begin
            tx_q    <= shift_q[0];
            cnt_q   <= '0;
            state_q <= ST_DATA;
          end
          ST_DATA: begin
            if (cnt_q != LAST_DATA) begin
              cnt_q <= cnt_q + 1'b1;
              tx_q  <= shift_q[1];
            end else if (PARITY != 0) begin
              tx_q    <= par_q;
              state_q <= ST_PAR;
            end else begin
              tx_q    <= 1'b1;
              stop_q  <= 1'b0;
              state_q <= ST_STOP;
            end
          end
          ST_PAR: begin
            tx_q    <= 1'b1;
            stop_q  <= 1'b0;
            state_q <= ST_STOP;
          end
          ST_STOP: begin
            if (!stop_done) begin
              stop_q <= 1'b1;
            end else begin
              tx_q    <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // Data registers carry no reset; full_q and the FSM decide whether they are meaningful
  always_ff @(posedge clk) begin
    if (accept) begin
      buf_q <= bus.tx_data;
    end
    if (load) begin
      shift_q <= buf_q;
      par_q   <= (^buf_q) ^ (PARITY == 1);
    end else if (shift_en) begin
      shift_q <= shift_q >> 1;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: three configurations share clock, reset and baud level;
// a monitor rebuilds each frame from the line at every baud strobe and pops the expected frame.
`timescale 1ns/1ps
module tb_uart_tx_serializer;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic baud_tick = 1'b0;
  int   mode = 0;   // 0: 16-clk baud, 1: baud held high, 2: 25 MHz / 115200 generator

  logic tx_a, tx_b, tx_c, busy_a, busy_b, busy_c;
  logic [2:0] tx_w, busy_w, rdy_w;

  uart_tx_serializer_if #(.DATA_BITS(8)) ifa ();
  uart_tx_serializer_if #(.DATA_BITS(8)) ifb ();
  uart_tx_serializer_if #(.DATA_BITS(8)) ifc ();

  uart_tx_serializer #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick), .bus(ifa), .tx(tx_a), .tx_busy(busy_a));
  uart_tx_serializer #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) dut_b (
    .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick), .bus(ifb), .tx(tx_b), .tx_busy(busy_b));
  uart_tx_serializer #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut_c (
    .clk(clk), .reset_n(reset_n), .baud_tick(baud_tick), .bus(ifc), .tx(tx_c), .tx_busy(busy_c));

  assign tx_w   = {tx_c, tx_b, tx_a};
  assign busy_w = {busy_c, busy_b, busy_a};
  assign rdy_w  = {ifc.tx_ready, ifb.tx_ready, ifa.tx_ready};

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  typedef struct {
    logic [15:0] bits;   // bit i = i-th line bit of the frame, start bit first
    bit          b2b;    // start bit directly follows the previous frame's last stop bit
  } exp_t;

  exp_t sbq[3][$];
  int   fl[3] = '{10, 12, 11};

  // Baud level driver, updated away from both the active edge and the stimulus slot
  int bcnt = 0;
  int bacc = 0;
  initial forever begin
    @(posedge clk);
    #2;
    bcnt = (bcnt + 1) % 16;
    bacc = bacc + 115200;
    if (bacc >= 25000000) bacc = bacc - 25000000;
    case (mode)
      0:       baud_tick = (bcnt < 8);
      1:       baud_tick = 1'b1;
      default: baud_tick = (bacc < 12500000);
    endcase
  end

  // Monitor: pend marks that the coming posedge sees a rising baud level
  logic [15:0] acc[3];
  int          idx[3];
  bit          infr[3];
  bit          lastend[3];
  bit          cur_b2b[3];
  logic [2:0]  last_tx = 3'b111;
  bit          pend = 1'b0;
  bit          lastbt = 1'b0;
  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      pend = 1'b0;
      lastbt = 1'b0;
      last_tx = 3'b111;
      for (int g = 0; g < 3; g++) begin
        infr[g] = 1'b0;
        lastend[g] = 1'b0;
        idx[g] = 0;
      end
    end else begin
      for (int g = 0; g < 3; g++) begin
        if (!pend) begin
          chk($sformatf("tx_change_off_strobe%0d", g), 32'(tx_w[g] != last_tx[g]), 32'd0);
        end else if (!infr[g] && tx_w[g] == 1'b0) begin
          infr[g] = 1'b1;
          idx[g] = 1;
          acc[g] = '0;
          cur_b2b[g] = lastend[g];
          lastend[g] = 1'b0;
          chk($sformatf("busy_in_frame%0d", g), 32'(busy_w[g]), 32'd1);
        end else if (infr[g]) begin
          acc[g][idx[g]] = tx_w[g];
          idx[g]++;
          chk($sformatf("busy_in_frame%0d", g), 32'(busy_w[g]), 32'd1);
          if (idx[g] == fl[g]) begin
            infr[g] = 1'b0;
            lastend[g] = 1'b1;
            chk($sformatf("frame_expected%0d", g), 32'(sbq[g].size() != 0), 32'd1);
            if (sbq[g].size() != 0) begin
              exp_t e;
              e = sbq[g].pop_front();
              chk($sformatf("frame_bits%0d", g), 32'(acc[g]), 32'(e.bits));
              chk($sformatf("frame_b2b%0d", g), 32'(cur_b2b[g]), 32'(e.b2b));
            end
          end
        end else begin
          lastend[g] = 1'b0;
          chk($sformatf("busy_idle%0d", g), 32'(busy_w[g]), 32'd0);
        end
        last_tx[g] = tx_w[g];
      end
      pend = baud_tick && !lastbt;
      lastbt = baud_tick;
    end
  end

  task automatic clks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int d, input logic [7:0] data, input logic v);
    case (d)
      0:       begin ifa.tx_data = data; ifa.tx_valid = v; end
      1:       begin ifb.tx_data = data; ifb.tx_valid = v; end
      default: begin ifc.tx_data = data; ifc.tx_valid = v; end
    endcase
  endtask

  task automatic send(input int d, input logic [7:0] data, input logic [15:0] bits,
                      input bit b2b, input bit expect_frame);
    int n;
    exp_t e;
    n = 0;
    while (rdy_w[d] !== 1'b1 && n < 20000) begin
      clks(1);
      n++;
    end
    chk("ready_wait", 32'(n < 20000), 32'd1);
    if (expect_frame) begin
      e.bits = bits;
      e.b2b = b2b;
      sbq[d].push_back(e);
    end
    drive(d, data, 1'b1);
    clks(1);
    drive(d, 8'hFF, 1'b0);
    chk("ready_low_after_accept", 32'(rdy_w[d]), 32'd0);
  endtask

  task automatic drain(input int d, input int max);
    int n;
    n = 0;
    while (sbq[d].size() != 0 && n < max) begin
      clks(1);
      n++;
    end
    chk("drain", 32'(n < max), 32'd1);
    clks(40);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    drive(0, 8'h00, 1'b0);
    drive(1, 8'h00, 1'b0);
    drive(2, 8'h00, 1'b0);
    reset_n = 1'b0;
    clks(3);
    for (int d = 0; d < 3; d++) begin
      chk("reset_tx", 32'(tx_w[d]), 32'd1);
      chk("reset_busy", 32'(busy_w[d]), 32'd0);
      chk("reset_ready", 32'(rdy_w[d]), 32'd1);
    end
    reset_n = 1'b1;
    clks(2);

    // 0x55 framed as {stop, data, start}: 1_01010101_0
    send(0, 8'h55, 16'h02AA, 1'b0, 1'b1);
    drain(0, 1000);

    // 0xA5 then 0x3C accepted while the first is shifting
    send(0, 8'hA5, 16'h034A, 1'b0, 1'b1);
    n = 0;
    while (busy_w[0] !== 1'b1 && n < 200) begin clks(1); n++; end
    chk("busy_wait", 32'(n < 200), 32'd1);
    clks(2);
    chk("ready_while_shifting", 32'(rdy_w[0]), 32'd1);
    send(0, 8'h3C, 16'h0278, 1'b1, 1'b1);
    drain(0, 1000);

    // 0x96 with the baud level held high for 100 clks mid-frame
    send(0, 8'h96, 16'h032C, 1'b0, 1'b1);
    n = 0;
    while (!(infr[0] && idx[0] >= 4) && n < 1000) begin clks(1); n++; end
    chk("held_tick_wait", 32'(n < 1000), 32'd1);
    n = 0;
    while (baud_tick && n < 100) begin clks(1); n++; end
    mode = 1;
    clks(100);
    mode = 0;
    drain(0, 2000);

    // 0x07: three ones, so even parity bit 1, odd parity bit 0
    send(1, 8'h07, 16'h0E0E, 1'b0, 1'b1);
    send(2, 8'h07, 16'h040E, 1'b0, 1'b1);
    drain(1, 1000);
    drain(2, 1000);

    // 0xF0 abandoned by reset during data bit 3 (a 0 on the line)
    send(0, 8'hF0, 16'h0000, 1'b0, 1'b0);
    n = 0;
    while (!(infr[0] && idx[0] == 5) && n < 1000) begin clks(1); n++; end
    chk("reset_point_wait", 32'(n < 1000), 32'd1);
    clks(3);
    chk("tx_data_bit3", 32'(tx_w[0]), 32'd0);
    reset_n = 1'b0;
    #1;
    chk("midreset_tx", 32'(tx_w[0]), 32'd1);
    chk("midreset_ready", 32'(rdy_w[0]), 32'd1);
    chk("midreset_busy", 32'(busy_w[0]), 32'd0);
    clks(3);
    reset_n = 1'b1;
    clks(2);
    send(0, 8'h81, 16'h0302, 1'b0, 1'b1);
    drain(0, 1000);

    // Real generator cadence, two back-to-back bytes
    mode = 2;
    clks(300);
    send(0, 8'hC3, 16'h0386, 1'b0, 1'b1);
    send(0, 8'h5A, 16'h02B4, 1'b1, 1'b1);
    drain(0, 10000);

    for (int d = 0; d < 3; d++) begin
      chk("queue_empty_at_end", 32'(sbq[d].size()), 32'd0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
